ghost_controller: RTL and testbench

GHOST_CONTROLLER -- requirements
Module: ghost_controller

---
 rtl/ghost_pkg.sv | 33 +++
 rtl/ghost_steer.sv | 68 ++++++
 rtl/ghost_controller.sv | 191 +++++++++++++++++++
 tb/tb_ghost_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// ghost_pkg: shared constants and helpers for the ghost controller.
//   - One-hot direction codes {L,U,R,D}
//   - Mode/state encodings (also the value driven on the mode output)
//   - LFSR tap mask and next-state / reversal helper functions
package ghost_pkg;

  // One-hot directions, bit order {L,U,R,D}
  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {
    ST_CHASE   = 2'b00,
    ST_SCATTER = 2'b01,
    ST_FRIGHT  = 2'b10,
    ST_EATEN   = 2'b11
  } ghost_state_e;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fibonacci LFSR step: the feedback bit is the parity of the tapped bits
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Swapping the two halves maps L<->R and U<->D in the {L,U,R,D} encoding
  function automatic logic [3:0] dir_reverse(input logic [3:0] d);
    return {d[1:0], d[3:2]};
  endfunction

endpackage

// File: rtl/ghost_steer.sv
// ghost_steer: combinational turn chooser used when the current direction is
// blocked.
// Ports:
//   dir       current one-hot direction {L,U,R,D}
//   open_*    passability of each direction (boundary blocking already folded in)
//   dx, dy    signed target-minus-position deltas (W+1 bits)
//   fright    1 = choose the preferred perpendicular from rnd
//   rnd       random bit (1 prefers D or R)
//   next_dir  chosen direction
module ghost_steer
  import ghost_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [3:0]       dir,
  input  logic             open_l,
  input  logic             open_u,
  input  logic             open_r,
  input  logic             open_d,
  input  logic signed [W:0] dx,
  input  logic signed [W:0] dy,
  input  logic             fright,
  input  logic             rnd,
  output logic [3:0]       next_dir
);

  logic       vertical_s;
  logic       pos_s;
  logic [3:0] open_s;
  logic [3:0] pref_s;
  logic [3:0] alt_s;
  logic [3:0] rev_s;

  assign open_s = {open_l, open_u, open_r, open_d};

  // Preferred/alternate perpendiculars and the final priority pick
  always_comb begin
    vertical_s = dir[2] | dir[0];
    // A zero delta is treated as negative, so only a strictly positive delta
    // selects D or R
    if (fright) begin
      pos_s = rnd;
    end else if (vertical_s) begin
      pos_s = !dx[W] && (dx != {(W+1){1'b0}});
    end else begin
      pos_s = !dy[W] && (dy != {(W+1){1'b0}});
    end

    if (vertical_s) begin
      pref_s = pos_s ? DIR_R : DIR_L;
    end else begin
      pref_s = pos_s ? DIR_D : DIR_U;
    end
    alt_s = dir_reverse(pref_s);
    rev_s = dir_reverse(dir);

    if ((pref_s & open_s) != 4'b0000) begin
      next_dir = pref_s;
    end else if ((alt_s & open_s) != 4'b0000) begin
      next_dir = alt_s;
    end else if ((rev_s & open_s) != 4'b0000) begin
      next_dir = rev_s;
    end else begin
      next_dir = dir;
    end
  end

endmodule

// File: rtl/ghost_controller.sv
// ghost_controller: maze ghost with CHASE/SCATTER/FRIGHT/EATEN behaviour.
// Ports:
//   clk_50mhz        sole clock (rising edge)
//   rst_n            synchronous active-low reset
//   move_tick        one-cycle step strobe
//   mode_req         requested mode (00 CHASE, 01 SCATTER, 10 FRIGHT, 11 CHASE)
//   eaten            pacman touched this ghost (honoured only in FRIGHT)
//   p_x, p_y         pacman position (CHASE target)
//   open_l/u/r/d     passability of a step in each direction
//   m_x, m_y         registered ghost position
//   dir              registered one-hot direction {L,U,R,D}
//   mode             registered current state
module ghost_controller
  import ghost_pkg::*;
#(
  parameter int          W         = 9,
  parameter int          VEL       = 1,
  parameter int          HOME_X    = 180,
  parameter int          HOME_Y    = 180,
  parameter int          SCAT_X    = 20,
  parameter int          SCAT_Y    = 30,
  parameter logic [3:0]  START_DIR = 4'b0100,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk_50mhz,
  input  logic         rst_n,
  input  logic         move_tick,
  input  logic [1:0]   mode_req,
  input  logic         eaten,
  input  logic [W-1:0] p_x,
  input  logic [W-1:0] p_y,
  input  logic         open_l,
  input  logic         open_u,
  input  logic         open_r,
  input  logic         open_d,
  output logic [W-1:0] m_x,
  output logic [W-1:0] m_y,
  output logic [3:0]   dir,
  output logic [1:0]   mode
);

  localparam logic [W-1:0] HOME_X_C = W'(HOME_X);
  localparam logic [W-1:0] HOME_Y_C = W'(HOME_Y);
  localparam logic [W-1:0] SCAT_X_C = W'(SCAT_X);
  localparam logic [W-1:0] SCAT_Y_C = W'(SCAT_Y);
  localparam logic [W-1:0] VEL_C    = W'(VEL);
  localparam logic [W-1:0] MAX_C    = {W{1'b1}};

  ghost_state_e   state_r, state_n;
  ghost_state_e   req_s;
  logic [3:0]     dir_r, dir_n;
  logic [W-1:0]   m_x_r, m_x_n;
  logic [W-1:0]   m_y_r, m_y_n;
  logic [15:0]    lfsr_r;
  logic [W-1:0]   tx_s, ty_s;
  logic signed [W:0] dx_s, dy_s;
  logic           ol_s, ou_s, or_s, od_s;
  logic           dir_open_s;
  logic           at_home_s;
  logic           trans_s;
  logic [3:0]     steer_dir_s;

  // A step that would leave 0..2^W-1 counts as blocked
  assign ol_s = open_l && (m_x_r >= VEL_C);
  assign or_s = open_r && (m_x_r <= (MAX_C - VEL_C));
  assign ou_s = open_u && (m_y_r >= VEL_C);
  assign od_s = open_d && (m_y_r <= (MAX_C - VEL_C));

  assign dir_open_s = ((dir_r & {ol_s, ou_s, or_s, od_s}) != 4'b0000);
  assign at_home_s  = (m_x_r == HOME_X_C) && (m_y_r == HOME_Y_C);

  // Target selection; FRIGHT steers randomly so its target is irrelevant
  always_comb begin
    case (state_r)
      ST_CHASE:   begin tx_s = p_x;      ty_s = p_y;      end
      ST_SCATTER: begin tx_s = SCAT_X_C; ty_s = SCAT_Y_C; end
      ST_EATEN:   begin tx_s = HOME_X_C; ty_s = HOME_Y_C; end
      default:    begin tx_s = p_x;      ty_s = p_y;      end
    endcase
  end

  assign dx_s = $signed({1'b0, tx_s}) - $signed({1'b0, m_x_r});
  assign dy_s = $signed({1'b0, ty_s}) - $signed({1'b0, m_y_r});

  // Decode of the requested mode; 11 falls back to CHASE
  always_comb begin
    case (mode_req)
      2'b01:   req_s = ST_SCATTER;
      2'b10:   req_s = ST_FRIGHT;
      default: req_s = ST_CHASE;
    endcase
  end

  ghost_steer #(.W(W)) u_steer (
    .dir      (dir_r),
    .open_l   (ol_s),
    .open_u   (ou_s),
    .open_r   (or_s),
    .open_d   (od_s),
    .dx       (dx_s),
    .dy       (dy_s),
    .fright   (state_r == ST_FRIGHT),
    .rnd      (lfsr_r[0]),
    .next_dir (steer_dir_s)
  );

  // Next-state logic: mode transitions first, then move or turn on a tick
  always_comb begin
    state_n = state_r;
    dir_n   = dir_r;
    m_x_n   = m_x_r;
    m_y_n   = m_y_r;
    trans_s = 1'b0;

    case (state_r)
      ST_FRIGHT: begin
        if (eaten) begin
          state_n = ST_EATEN;
          trans_s = 1'b1;
        end else if (req_s != state_r) begin
          state_n = req_s;
          dir_n   = dir_reverse(dir_r);
          trans_s = 1'b1;
        end else begin
          trans_s = 1'b0;
        end
      end
      ST_CHASE, ST_SCATTER: begin
        if (req_s != state_r) begin
          state_n = req_s;
          dir_n   = dir_reverse(dir_r);
          trans_s = 1'b1;
        end else begin
          trans_s = 1'b0;
        end
      end
      ST_EATEN: begin
        if (at_home_s) begin
          state_n = (mode_req == 2'b01) ? ST_SCATTER : ST_CHASE;
          trans_s = 1'b1;
        end else begin
          trans_s = 1'b0;
        end
      end
      default: begin
        state_n = ST_CHASE;
        trans_s = 1'b1;
      end
    endcase

    // A transition in the same cycle swallows the tick
    if (!trans_s && move_tick) begin
      if (dir_open_s) begin
        case (dir_r)
          DIR_L:   m_x_n = m_x_r - VEL_C;
          DIR_R:   m_x_n = m_x_r + VEL_C;
          DIR_U:   m_y_n = m_y_r - VEL_C;
          DIR_D:   m_y_n = m_y_r + VEL_C;
          default: m_x_n = m_x_r;
        endcase
      end else begin
        dir_n = steer_dir_s;
      end
    end else begin
      m_x_n = m_x_r;
    end
  end

  // State, position, direction and LFSR registers with synchronous reset
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_r <= ST_CHASE;
      dir_r   <= START_DIR;
      m_x_r   <= HOME_X_C;
      m_y_r   <= HOME_Y_C;
      lfsr_r  <= LFSR_SEED;
    end else begin
      state_r <= state_n;
      dir_r   <= dir_n;
      m_x_r   <= m_x_n;
      m_y_r   <= m_y_n;
      lfsr_r  <= lfsr_next(lfsr_r);
    end
  end

  assign m_x  = m_x_r;
  assign m_y  = m_y_r;
  assign dir  = dir_r;
  assign mode = state_r;

endmodule

// File: tb/tb_ghost_controller.sv
// Self-checking bench for ghost_controller: a behavioural model predicts the
// state after every clock edge and pushes it to a queue; a monitor pops and
// compares one entry after each rising edge. Directed scenarios add constant
// checks, followed by a randomized phase.
module tb_ghost_controller;

  localparam int W = 9, VEL = 1, HX = 180, HY = 180, SX = 20, SY = 30;
  localparam int MAXC = 511;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0, move_tick = 1'b0, eaten = 1'b0;
  logic [1:0]   mode_req = 2'b00;
  logic [W-1:0] p_x = '0, p_y = '0;
  logic         open_l = 1'b1, open_u = 1'b1, open_r = 1'b1, open_d = 1'b1;
  logic [W-1:0] m_x, m_y;
  logic [3:0]   dir;
  logic [1:0]   mode;

  always #10 clk = ~clk;

  ghost_controller dut (
    .clk_50mhz(clk), .rst_n(rst_n), .move_tick(move_tick), .mode_req(mode_req),
    .eaten(eaten), .p_x(p_x), .p_y(p_y), .open_l(open_l), .open_u(open_u),
    .open_r(open_r), .open_d(open_d), .m_x(m_x), .m_y(m_y), .dir(dir), .mode(mode)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [3:0] d;
    logic [1:0] m;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // Model state: direction index 0=L 1=U 2=R 3=D; mode 0..3 as in mode output
  int mx, my, dk, st;
  logic [15:0] lf;
  int ddx[4] = '{-1, 0, 1, 0};
  int ddy[4] = '{0, -1, 0, 1};

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic bit can_go(input int k, input logic [3:0] op);
    int nx, ny;
    nx = mx + VEL * ddx[k];
    ny = my + VEL * ddy[k];
    return op[3-k] && nx >= 0 && nx <= MAXC && ny >= 0 && ny <= MAXC;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [1:0] mr,
                            input logic e, input int px, input int py,
                            input logic [3:0] op);
    int req, tx, ty, pref, alt, rev;
    bit trans, pos, vert;
    if (!r) begin
      mx = HX; my = HY; dk = 1; st = 0; lf = 16'hACE1;
      return;
    end
    req = (mr == 2'b01) ? 1 : (mr == 2'b10) ? 2 : 0;
    trans = 0;
    if (st == 2 && e) begin
      st = 3; trans = 1;
    end else if (st != 3 && req != st) begin
      st = req; dk = (dk + 2) % 4; trans = 1;
    end else if (st == 3 && mx == HX && my == HY) begin
      st = (mr == 2'b01) ? 1 : 0; trans = 1;
    end
    if (!trans && t) begin
      if (can_go(dk, op)) begin
        mx += VEL * ddx[dk];
        my += VEL * ddy[dk];
      end else begin
        vert = (dk % 2 == 1);
        if (st == 2) pos = lf[0];
        else begin
          tx = (st == 0) ? px : (st == 1) ? SX : HX;
          ty = (st == 0) ? py : (st == 1) ? SY : HY;
          pos = vert ? (tx > mx) : (ty > my);
        end
        pref = vert ? (pos ? 2 : 0) : (pos ? 3 : 1);
        alt = (pref + 2) % 4;
        rev = (dk + 2) % 4;
        if (can_go(pref, op)) dk = pref;
        else if (can_go(alt, op)) dk = alt;
        else if (can_go(rev, op)) dk = rev;
      end
    end
    lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
  endtask

  // Drive one cycle of inputs at the falling edge and queue the prediction
  task automatic step(input logic r, input logic t, input logic [1:0] mr,
                      input logic e, input int px, input int py,
                      input logic [3:0] op);
    exp_t ex;
    logic [3:0] one;
    @(negedge clk);
    rst_n = r; move_tick = t; mode_req = mr; eaten = e;
    p_x = W'(px); p_y = W'(py);
    {open_l, open_u, open_r, open_d} = op;
    model_step(r, t, mr, e, px, py, op);
    one = 4'b1000;
    ex.x = 9'(mx); ex.y = 9'(my); ex.d = one >> dk; ex.m = 2'(st);
    q.push_back(ex);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 4'b1111);
  endtask

  // Monitor: one expected entry per rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_m_x", int'(m_x), int'(e.x));
        chk("sb_m_y", int'(m_y), int'(e.y));
        chk("sb_dir", int'(dir), int'(e.d));
        chk("sb_mode", int'(mode), int'(e.m));
      end
    end
  end

  initial begin : driver
    bit done;
    logic [1:0] mr;
    // Reset state
    do_reset(); settle();
    chk("rst_x", int'(m_x), 180); chk("rst_y", int'(m_y), 180);
    chk("rst_dir", int'(dir), 4); chk("rst_mode", int'(mode), 0);

    // Three ticks straight up
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 1'b0, 180, 180, 4'b1111);
    settle();
    chk("walk_y", int'(m_y), 177); chk("walk_x", int'(m_x), 180); chk("walk_mode", int'(mode), 0);

    // Blocked up with target to the right -> R; with R also blocked -> L
    step(1'b1, 1'b1, 2'b00, 1'b0, 200, 100, 4'b1011); settle();
    chk("turn_r", int'(dir), 2); chk("turn_r_y", int'(m_y), 177);
    do_reset();
    step(1'b1, 1'b1, 2'b00, 1'b0, 200, 100, 4'b1001); settle();
    chk("turn_l", int'(dir), 8); chk("turn_l_x", int'(m_x), 180);

    // Only D open -> reverse; nothing open -> hold
    do_reset();
    step(1'b1, 1'b1, 2'b00, 1'b0, 200, 100, 4'b0001); settle();
    chk("rev_d", int'(dir), 1);
    step(1'b1, 1'b1, 2'b00, 1'b0, 200, 100, 4'b0000); settle();
    chk("hold_dir", int'(dir), 1); chk("hold_y", int'(m_y), 180);

    // CHASE -> FRIGHT reverses, eaten -> EATEN, walk home -> SCATTER
    do_reset();
    step(1'b1, 1'b0, 2'b10, 1'b0, 0, 0, 4'b1111); settle();
    chk("fright_mode", int'(mode), 2); chk("fright_dir", int'(dir), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b10, 1'b0, 0, 0, 4'b1111);
    step(1'b1, 1'b0, 2'b10, 1'b1, 0, 0, 4'b1111); settle();
    chk("eaten_mode", int'(mode), 3); chk("eaten_y", int'(m_y), 183);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b1, 1'b1, 2'b01, 1'b0, 0, 0, 4'b0100); settle();
      if (mode == 2'b01) done = 1;
    end
    chk("home_reached", int'(done), 1);
    chk("home_mode", int'(mode), 1); chk("home_y", int'(m_y), 180);

    // eaten together with a tick in FRIGHT: mode wins, no motion
    do_reset();
    step(1'b1, 1'b0, 2'b10, 1'b0, 0, 0, 4'b1111);
    step(1'b1, 1'b1, 2'b10, 1'b1, 0, 0, 4'b1111); settle();
    chk("eat_tick_mode", int'(mode), 3);
    chk("eat_tick_x", int'(m_x), 180); chk("eat_tick_y", int'(m_y), 180);

    // Walk to the right edge, then a tick at x=511 must turn, not wrap
    do_reset();
    step(1'b1, 1'b1, 2'b00, 1'b0, 200, 180, 4'b0011);
    for (int i = 0; i < 331; i++) step(1'b1, 1'b1, 2'b00, 1'b0, 200, 180, 4'b1111);
    settle();
    chk("edge_x", int'(m_x), 511);
    step(1'b1, 1'b1, 2'b00, 1'b0, 200, 300, 4'b1111); settle();
    chk("edge_hold_x", int'(m_x), 511); chk("edge_turn", int'(dir), 1);

    // Randomized phase
    do_reset();
    mr = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) mr = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), mr,
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 511)),
           int'($urandom_range(0, 511)),
           {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
    end
    settle(); settle();
    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
